// File: rtl/riscv_pkg.sv
// Shared RV32I operand-stage types: operand source selectors and datapath constants.
package riscv_pkg;

    localparam int XLEN_DEF   = 32;
    localparam int OPB_CONST4 = 4;

    typedef enum logic [1:0] {
        OPA_RS1  = 2'd0,
        OPA_PC   = 2'd1,
        OPA_ZERO = 2'd2,
        OPA_RSVD = 2'd3
    } opa_sel_e;

    typedef enum logic [1:0] {
        OPB_RS2  = 2'd0,
        OPB_IMM  = 2'd1,
        OPB_C4   = 2'd2,
        OPB_RSVD = 2'd3
    } opb_sel_e;

    function automatic logic uses_rs1(opa_sel_e sel);
        return sel == OPA_RS1;
    endfunction

endpackage

// File: rtl/opnd_fwd_stage_if.sv
// Decoder/regfile-side and EX-side signal bundle of the ID/EX operand stage.
interface opnd_fwd_stage_if
    import riscv_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int RA_W  = 5,
    parameter int CNT_W = 16
);
    logic             i_valid;
    logic             o_ready;
    opa_sel_e         i_opa_sel;
    opb_sel_e         i_opb_sel;
    logic [RA_W-1:0]  i_rs1_addr;
    logic [RA_W-1:0]  i_rs2_addr;
    logic [XLEN-1:0]  i_rs1_data;
    logic [XLEN-1:0]  i_rs2_data;
    logic [XLEN-1:0]  i_pc;
    logic [XLEN-1:0]  i_imm;
    logic             i_mem_we;
    logic [RA_W-1:0]  i_mem_rd;
    logic [XLEN-1:0]  i_mem_data;
    logic             i_wb_we;
    logic [RA_W-1:0]  i_wb_rd;
    logic [XLEN-1:0]  i_wb_data;
    logic [RA_W-1:0]  i_rd;
    logic             i_is_load;
    logic             i_flush;
    logic             o_valid;
    logic             i_ready;
    logic [XLEN-1:0]  o_operand_a;
    logic [XLEN-1:0]  o_operand_b;
    logic [XLEN-1:0]  o_rs2_fwd;
    logic [RA_W-1:0]  o_rd;
    logic             o_is_load;
    logic [CNT_W-1:0] o_stall_cnt;

    modport master (
        output i_valid, i_opa_sel, i_opb_sel, i_rs1_addr, i_rs2_addr,
               i_rs1_data, i_rs2_data, i_pc, i_imm,
               i_mem_we, i_mem_rd, i_mem_data, i_wb_we, i_wb_rd, i_wb_data,
               i_rd, i_is_load, i_flush, i_ready,
        input  o_ready, o_valid, o_operand_a, o_operand_b, o_rs2_fwd,
               o_rd, o_is_load, o_stall_cnt
    );

    modport slave (
        input  i_valid, i_opa_sel, i_opb_sel, i_rs1_addr, i_rs2_addr,
               i_rs1_data, i_rs2_data, i_pc, i_imm,
               i_mem_we, i_mem_rd, i_mem_data, i_wb_we, i_wb_rd, i_wb_data,
               i_rd, i_is_load, i_flush, i_ready,
        output o_ready, o_valid, o_operand_a, o_operand_b, o_rs2_fwd,
               o_rd, o_is_load, o_stall_cnt
    );
endinterface

// File: rtl/fwd_sel.sv
// One source-register forwarding mux: EX/MEM beats MEM/WB beats regfile; x0 is hard zero.
module fwd_sel #(
    parameter int XLEN = 32,
    parameter int RA_W = 5
) (
    input  logic [RA_W-1:0] addr,
    input  logic [XLEN-1:0] rf_data,
    input  logic            mem_we,
    input  logic [RA_W-1:0] mem_rd,
    input  logic [XLEN-1:0] mem_data,
    input  logic            wb_we,
    input  logic [RA_W-1:0] wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic [XLEN-1:0] data
);
    always_comb begin
        data = rf_data;
        if (addr == '0)
            data = '0;
        else if (mem_we && (mem_rd == addr))
            data = mem_data;
        else if (wb_we && (wb_rd == addr))
            data = wb_data;
    end
endmodule

// File: rtl/opnd_fwd_stage.sv
// Registered ID/EX operand stage: forwarded operand select, load-use bubble insertion,
// single-entry valid/ready register with flush and saturating stall counter.
module opnd_fwd_stage
    import riscv_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int RA_W  = 5,
    parameter int CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    opnd_fwd_stage_if.slave  bus
);
    logic [1:0][RA_W-1:0] src_addr;
    logic [1:0][XLEN-1:0] src_rf;
    logic [1:0][XLEN-1:0] src_fwd;

    assign src_addr = {bus.i_rs2_addr, bus.i_rs1_addr};
    assign src_rf   = {bus.i_rs2_data, bus.i_rs1_data};

    for (genvar s = 0; s < 2; s++) begin : g_fwd
        fwd_sel #(.XLEN(XLEN), .RA_W(RA_W)) u_fwd (
            .addr     (src_addr[s]),
            .rf_data  (src_rf[s]),
            .mem_we   (bus.i_mem_we),
            .mem_rd   (bus.i_mem_rd),
            .mem_data (bus.i_mem_data),
            .wb_we    (bus.i_wb_we),
            .wb_rd    (bus.i_wb_rd),
            .wb_data  (bus.i_wb_data),
            .data     (src_fwd[s])
        );
    end

    logic [XLEN-1:0] opa_nxt, opb_nxt;

    always_comb begin
        opa_nxt = '0;
        unique case (bus.i_opa_sel)
            OPA_RS1: opa_nxt = src_fwd[0];
            OPA_PC:  opa_nxt = bus.i_pc;
            default: opa_nxt = '0;
        endcase
    end

    always_comb begin
        opb_nxt = '0;
        unique case (bus.i_opb_sel)
            OPB_RS2: opb_nxt = src_fwd[1];
            OPB_IMM: opb_nxt = bus.i_imm;
            OPB_C4:  opb_nxt = XLEN'(OPB_CONST4);
            default: opb_nxt = '0;
        endcase
    end

    logic             vld_q, ld_q;
    logic [RA_W-1:0]  rd_q;
    logic [XLEN-1:0]  opa_q, opb_q, rs2_q;
    logic [CNT_W-1:0] cnt_q;
    logic             hazard, can_adv;

    // rs2 is always live (store data travels on o_rs2_fwd), so its match needs no selector qualifier.
    assign hazard  = vld_q && ld_q && (rd_q != '0) &&
                     ((uses_rs1(bus.i_opa_sel) && (rd_q == bus.i_rs1_addr)) ||
                      (rd_q == bus.i_rs2_addr));
    assign can_adv = !vld_q || bus.i_ready;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            vld_q <= 1'b0;
            ld_q  <= 1'b0;
            rd_q  <= '0;
            opa_q <= '0;
            opb_q <= '0;
            rs2_q <= '0;
            cnt_q <= '0;
        end else if (bus.i_flush) begin
            vld_q <= 1'b0;
        end else if (can_adv && hazard && bus.i_valid) begin
            vld_q <= 1'b0;
            if (cnt_q != {CNT_W{1'b1}})
                cnt_q <= cnt_q + CNT_W'(1);
        end else if (can_adv && bus.i_valid) begin
            vld_q <= 1'b1;
            ld_q  <= bus.i_is_load;
            rd_q  <= bus.i_rd;
            opa_q <= opa_nxt;
            opb_q <= opb_nxt;
            rs2_q <= src_fwd[1];
        end else if (can_adv) begin
            vld_q <= 1'b0;
        end
    end

    assign bus.o_ready     = can_adv && !hazard;
    assign bus.o_valid     = vld_q;
    assign bus.o_is_load   = ld_q;
    assign bus.o_rd        = rd_q;
    assign bus.o_operand_a = opa_q;
    assign bus.o_operand_b = opb_q;
    assign bus.o_rs2_fwd   = rs2_q;
    assign bus.o_stall_cnt = cnt_q;
endmodule

// File: tb/tb_opnd_fwd_stage.sv
// Directed bench for opnd_fwd_stage: operand/forwarding vector table plus hazard,
// hold, flush, counter-saturation and async-reset sequences on a 16-bit and a 2-bit counter build.
module tb_opnd_fwd_stage;
    import riscv_pkg::*;

    logic i_clk = 1'b0;
    logic i_rst_n;
    always #5 i_clk = ~i_clk;

    opnd_fwd_stage_if #(.XLEN(32), .RA_W(5), .CNT_W(16)) bus ();
    opnd_fwd_stage_if #(.XLEN(32), .RA_W(5), .CNT_W(2))  bus2 ();

    opnd_fwd_stage #(.XLEN(32), .RA_W(5), .CNT_W(16)) dut (
        .i_clk (i_clk), .i_rst_n (i_rst_n), .bus (bus.slave));
    opnd_fwd_stage #(.XLEN(32), .RA_W(5), .CNT_W(2)) dut_sat (
        .i_clk (i_clk), .i_rst_n (i_rst_n), .bus (bus2.slave));

    // The narrow-counter copy sees exactly the same stimulus.
    assign bus2.i_valid    = bus.i_valid;
    assign bus2.i_opa_sel  = bus.i_opa_sel;
    assign bus2.i_opb_sel  = bus.i_opb_sel;
    assign bus2.i_rs1_addr = bus.i_rs1_addr;
    assign bus2.i_rs2_addr = bus.i_rs2_addr;
    assign bus2.i_rs1_data = bus.i_rs1_data;
    assign bus2.i_rs2_data = bus.i_rs2_data;
    assign bus2.i_pc       = bus.i_pc;
    assign bus2.i_imm      = bus.i_imm;
    assign bus2.i_mem_we   = bus.i_mem_we;
    assign bus2.i_mem_rd   = bus.i_mem_rd;
    assign bus2.i_mem_data = bus.i_mem_data;
    assign bus2.i_wb_we    = bus.i_wb_we;
    assign bus2.i_wb_rd    = bus.i_wb_rd;
    assign bus2.i_wb_data  = bus.i_wb_data;
    assign bus2.i_rd       = bus.i_rd;
    assign bus2.i_is_load  = bus.i_is_load;
    assign bus2.i_flush    = bus.i_flush;
    assign bus2.i_ready    = bus.i_ready;

    typedef struct {
        opa_sel_e    opa;
        opb_sel_e    opb;
        logic [4:0]  ra1, ra2;
        logic [31:0] d1, d2, pc, imm;
        logic        mwe;
        logic [4:0]  mrd;
        logic [31:0] md;
        logic        wwe;
        logic [4:0]  wrd;
        logic [31:0] wd;
        logic [31:0] ea, eb, e2;
    } vec_t;

    vec_t vecs[6];
    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle();
        bus.i_valid    = 1'b0;
        bus.i_opa_sel  = OPA_RS1;
        bus.i_opb_sel  = OPB_RS2;
        bus.i_rs1_addr = '0;
        bus.i_rs2_addr = '0;
        bus.i_rs1_data = '0;
        bus.i_rs2_data = '0;
        bus.i_pc       = '0;
        bus.i_imm      = '0;
        bus.i_mem_we   = 1'b0;
        bus.i_mem_rd   = '0;
        bus.i_mem_data = '0;
        bus.i_wb_we    = 1'b0;
        bus.i_wb_rd    = '0;
        bus.i_wb_data  = '0;
        bus.i_rd       = '0;
        bus.i_is_load  = 1'b0;
        bus.i_flush    = 1'b0;
        bus.i_ready    = 1'b1;
    endtask

    initial begin
        vecs[0] = '{OPA_RS1, OPB_RS2, 5'd3, 5'd5, 32'h100, 32'h11, 32'h0, 32'h0,
                    1'b1, 5'd5, 32'hAA, 1'b1, 5'd5, 32'hBB, 32'h100, 32'hAA, 32'hAA};
        vecs[1] = '{OPA_RS1, OPB_C4, 5'd0, 5'd2, 32'h55, 32'h22, 32'h0, 32'h0,
                    1'b1, 5'd0, 32'hFF, 1'b1, 5'd0, 32'hEE, 32'h0, 32'h4, 32'h22};
        vecs[2] = '{OPA_PC, OPB_IMM, 5'd5, 5'd6, 32'h1, 32'h2, 32'h8000_0000, 32'hFFFF_FFF0,
                    1'b1, 5'd5, 32'hAA, 1'b1, 5'd6, 32'hBB, 32'h8000_0000, 32'hFFFF_FFF0, 32'hBB};
        vecs[3] = '{OPA_RS1, OPB_RS2, 5'd9, 5'd10, 32'h1, 32'h2, 32'h0, 32'h0,
                    1'b1, 5'd10, 32'h10, 1'b1, 5'd9, 32'h99, 32'h99, 32'h10, 32'h10};
        vecs[4] = '{OPA_RS1, OPB_RSVD, 5'd4, 5'd4, 32'h44, 32'h44, 32'h0, 32'h7,
                    1'b0, 5'd4, 32'hAA, 1'b0, 5'd4, 32'hBB, 32'h44, 32'h0, 32'h44};
        vecs[5] = '{OPA_RSVD, OPB_RS2, 5'd1, 5'd1, 32'h1, 32'h1, 32'h123, 32'h0,
                    1'b0, 5'd1, 32'hAA, 1'b1, 5'd1, 32'h77, 32'h0, 32'h77, 32'h77};

        idle();
        i_rst_n = 1'b0;
        repeat (2) @(posedge i_clk);
        #1;
        chk("rst_valid", 32'(bus.o_valid), 32'h0);
        chk("rst_opa", bus.o_operand_a, 32'h0);
        chk("rst_cnt", 32'(bus.o_stall_cnt), 32'h0);
        chk("rst_is_load", 32'(bus.o_is_load), 32'h0);
        @(negedge i_clk);
        i_rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            bus.i_valid    = 1'b1;
            bus.i_opa_sel  = vecs[i].opa;
            bus.i_opb_sel  = vecs[i].opb;
            bus.i_rs1_addr = vecs[i].ra1;
            bus.i_rs2_addr = vecs[i].ra2;
            bus.i_rs1_data = vecs[i].d1;
            bus.i_rs2_data = vecs[i].d2;
            bus.i_pc       = vecs[i].pc;
            bus.i_imm      = vecs[i].imm;
            bus.i_mem_we   = vecs[i].mwe;
            bus.i_mem_rd   = vecs[i].mrd;
            bus.i_mem_data = vecs[i].md;
            bus.i_wb_we    = vecs[i].wwe;
            bus.i_wb_rd    = vecs[i].wrd;
            bus.i_wb_data  = vecs[i].wd;
            bus.i_rd       = 5'(i + 1);
            tick();
            chk($sformatf("vec%0d_valid", i), 32'(bus.o_valid), 32'h1);
            chk($sformatf("vec%0d_opa", i), bus.o_operand_a, vecs[i].ea);
            chk($sformatf("vec%0d_opb", i), bus.o_operand_b, vecs[i].eb);
            chk($sformatf("vec%0d_rs2fwd", i), bus.o_rs2_fwd, vecs[i].e2);
            chk($sformatf("vec%0d_rd", i), 32'(bus.o_rd), 32'(i + 1));
        end

        // Load-use: load x7 in stage, consumer of x7 must bubble once then pick up WB forwarding.
        idle();
        bus.i_valid = 1'b1; bus.i_is_load = 1'b1; bus.i_rd = 5'd7;
        bus.i_rs1_addr = 5'd1; bus.i_opb_sel = OPB_IMM;
        tick();
        chk("ld_valid", 32'(bus.o_valid), 32'h1);
        chk("ld_is_load", 32'(bus.o_is_load), 32'h1);
        chk("ld_rd", 32'(bus.o_rd), 32'h7);
        bus.i_is_load = 1'b0; bus.i_rd = 5'd3; bus.i_rs1_addr = 5'd7;
        bus.i_opb_sel = OPB_C4; bus.i_rs2_addr = 5'd0;
        bus.i_wb_we = 1'b1; bus.i_wb_rd = 5'd7; bus.i_wb_data = 32'h1234;
        #1;
        chk("hz_ready_low", 32'(bus.o_ready), 32'h0);
        tick();
        chk("hz_bubble", 32'(bus.o_valid), 32'h0);
        chk("hz_cnt", 32'(bus.o_stall_cnt), 32'h1);
        chk("hz_ready_back", 32'(bus.o_ready), 32'h1);
        tick();
        chk("hz_cap_valid", 32'(bus.o_valid), 32'h1);
        chk("hz_cap_opa", bus.o_operand_a, 32'h1234);
        chk("hz_cap_opb", bus.o_operand_b, 32'h4);

        // Downstream freeze with toggling inputs.
        bus.i_ready = 1'b0;
        bus.i_opa_sel = OPA_PC;
        for (int k = 0; k < 3; k++) begin
            bus.i_pc = 32'h100 * (k + 1);
            bus.i_rs1_data = 32'hDEAD_0000 + k;
            #1;
            chk($sformatf("hold%0d_ready", k), 32'(bus.o_ready), 32'h0);
            tick();
            chk($sformatf("hold%0d_valid", k), 32'(bus.o_valid), 32'h1);
            chk($sformatf("hold%0d_opa", k), bus.o_operand_a, 32'h1234);
        end
        bus.i_ready = 1'b1;
        bus.i_pc = 32'hCAFE_0000;
        tick();
        chk("release_opa", bus.o_operand_a, 32'hCAFE_0000);

        // Flush coinciding with a load-use hazard: no stall count.
        idle();
        bus.i_valid = 1'b1; bus.i_is_load = 1'b1; bus.i_rd = 5'd9; bus.i_rs1_addr = 5'd1;
        tick();
        bus.i_is_load = 1'b0; bus.i_rd = 5'd2; bus.i_rs1_addr = 5'd9; bus.i_flush = 1'b1;
        #1;
        chk("fh_ready", 32'(bus.o_ready), 32'h0);
        tick();
        chk("fh_valid", 32'(bus.o_valid), 32'h0);
        chk("fh_cnt", 32'(bus.o_stall_cnt), 32'h1);
        bus.i_flush = 1'b0; bus.i_rs1_addr = 5'd2;
        tick();
        chk("pre_flush_valid", 32'(bus.o_valid), 32'h1);
        bus.i_flush = 1'b1;
        tick();
        chk("flush_valid", 32'(bus.o_valid), 32'h0);
        bus.i_flush = 1'b0;

        // Repeated self-dependent loads: bubble/capture pairs drive the counters up.
        idle();
        bus.i_valid = 1'b1; bus.i_is_load = 1'b1; bus.i_rd = 5'd7; bus.i_rs1_addr = 5'd7;
        bus.i_rs1_data = 32'h77; bus.i_opb_sel = OPB_IMM; bus.i_imm = 32'h5;
        bus.i_rs2_addr = 5'd3; bus.i_rs2_data = 32'h33;
        tick();
        for (int k = 0; k < 5; k++) begin
            tick();
            chk($sformatf("sat%0d_bubble", k), 32'(bus.o_valid), 32'h0);
            chk($sformatf("sat%0d_cnt16", k), 32'(bus.o_stall_cnt), 32'(2 + k));
            chk($sformatf("sat%0d_cnt2", k), 32'(bus2.o_stall_cnt), (k >= 1) ? 32'h3 : 32'h2);
            tick();
            chk($sformatf("sat%0d_cap", k), 32'(bus.o_valid), 32'h1);
        end
        chk("pre_rst_opa", bus.o_operand_a, 32'h77);

        // Async reset between edges.
        #2;
        i_rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(bus.o_valid), 32'h0);
        chk("arst_opa", bus.o_operand_a, 32'h0);
        chk("arst_opb", bus.o_operand_b, 32'h0);
        chk("arst_rs2", bus.o_rs2_fwd, 32'h0);
        chk("arst_rd", 32'(bus.o_rd), 32'h0);
        chk("arst_is_load", 32'(bus.o_is_load), 32'h0);
        chk("arst_cnt16", 32'(bus.o_stall_cnt), 32'h0);
        chk("arst_cnt2", 32'(bus2.o_stall_cnt), 32'h0);
        @(negedge i_clk);
        i_rst_n = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
